// File: rtl/instruction_sequencer.sv
// instruction_sequencer: steps through a 16-entry program memory and hands each
// opcode/literal pair to a downstream control unit with a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset (program memory is not cleared)
//   load_en    program memory write enable, ignored while busy
//   load_addr  program memory write index
//   load_data  instruction word: [12:8] opcode, [7:0] literal
//   start      begin execution at index 0 (accepted in IDLE, DONE, ERROR)
//   abort      return to IDLE at the next edge; wins over start and ready
//   ready      downstream accepts the presented opcode
//   address    opcode presented to the control unit
//   literal    operand accompanying the opcode
//   valid      address/literal valid for a handshake
//   busy       high in FETCH and ISSUE
//   done       sticky: program completed (HALT or end of memory)
//   error      sticky: illegal opcode fetched
//   pc         current program index
module instruction_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [3:0]  load_addr,
    input  logic [12:0] load_data,
    input  logic        start,
    input  logic        abort,
    input  logic        ready,
    output logic [4:0]  address,
    output logic [7:0]  literal,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  pc
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ERROR = 3'd4;

    localparam logic [4:0] LAST_LEGAL = 5'b11000;
    localparam logic [4:0] HALT       = 5'b11111;

    logic [12:0] mem [16];
    logic [2:0]  state;
    logic [12:0] word;
    logic [4:0]  opcode;

    assign busy   = (state == FETCH) || (state == ISSUE);
    assign word   = mem[pc];
    assign opcode = word[12:8];

    // Reset takes precedence over a load on the same edge, but never clears
    // the stored program.
    always_ff @(posedge clk) begin
        if (rst_n && load_en && !busy)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            address <= '0;
            literal <= '0;
            valid   <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            pc      <= '0;
        end else if (abort) begin
            state <= IDLE;
            valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (opcode <= LAST_LEGAL) begin
                        address <= opcode;
                        literal <= word[7:0];
                        valid   <= 1'b1;
                        state   <= ISSUE;
                    end else if (opcode == HALT) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        // pc stays on the offending index for diagnosis
                        error <= 1'b1;
                        state <= ERROR;
                    end
                end
                ISSUE: begin
                    if (ready) begin
                        valid <= 1'b0;
                        // the last index is an implicit halt; no wrap to 0
                        if (pc == 4'd15) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pc    <= pc + 4'd1;
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        pc    <= '0;
                        done  <= 1'b0;
                        error <= 1'b0;
                        state <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule
